pll_reset_seq: RTL and testbench



---
 rtl/pll_reset_seq_if.sv | 26 ++
 rtl/pll_reset_seq.sv | 122 ++++++++++++
 tb/tb_pll_reset_seq.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/pll_reset_seq_if.sv
// Signal bundle between the reset sequencer and its environment.
// The master side drives the PLL lock and software request inputs;
// the slave side (the sequencer) drives the reset and debug outputs.
interface pll_reset_seq_if;
  logic       pll_locked;
  logic       sw_rst_req;
  logic       reset_out_;
  logic [7:0] lock_loss_cnt;
  logic [1:0] seq_state;

  modport master (
    output pll_locked,
    output sw_rst_req,
    input  reset_out_,
    input  lock_loss_cnt,
    input  seq_state
  );

  modport slave (
    input  pll_locked,
    input  sw_rst_req,
    output reset_out_,
    output lock_loss_cnt,
    output seq_state
  );
endinterface

// File: rtl/pll_reset_seq.sv
// Reset sequencer behind the PLL: synchronizes LOCK, waits for it to stay
// high for LOCK_STABLE_CYCLES, holds reset a further HOLD_CYCLES, then
// releases the SoC reset. Lock loss or a software request re-asserts it.
// sw_rst_req is a level sampled on every rising clk edge; it acts only in RUN.
module pll_reset_seq #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES        = 16,
  parameter int CNT_WIDTH          = 11
) (
  input  logic            clk,
  input  logic            reset_,
  pll_reset_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] STABLE_LAST = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST   = CNT_WIDTH'(HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_locked_s;
  state_t                 r_state;
  state_t                 w_next_state;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [CNT_WIDTH-1:0]   w_cnt_next;
  logic                   w_loss_evt;
  logic [7:0]             r_loss_cnt;
  logic                   r_reset_out;
  logic                   w_reset_out_next;

  assign w_locked_s = r_sync[SYNC_STAGES-1];

  // LOCK synchronizer: shift the asynchronous PLL lock through SYNC_STAGES flops.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.pll_locked};
    end
  end

  // State register, cycle counter, saturating lock-loss counter, registered reset.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state     <= WAIT_LOCK;
      r_cnt       <= '0;
      r_loss_cnt  <= 8'd0;
      r_reset_out <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_cnt       <= w_cnt_next;
      r_reset_out <= w_reset_out_next;
      if (w_loss_evt && (r_loss_cnt != 8'hFF)) begin
        r_loss_cnt <= r_loss_cnt + 8'd1;
      end
    end
  end

  // Next-state logic: lock loss always wins, then counter expiry / soft reset.
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_loss_evt   = 1'b0;
    case (r_state)
      WAIT_LOCK: begin
        if (w_locked_s) begin
          w_next_state = STABLE;
          w_cnt_next   = '0;
        end
      end
      STABLE: begin
        if (!w_locked_s) begin
          w_next_state = WAIT_LOCK;
          w_loss_evt   = 1'b1;
        end else if (r_cnt == STABLE_LAST) begin
          w_next_state = HOLD;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_WIDTH'(1);
        end
      end
      HOLD: begin
        if (!w_locked_s) begin
          w_next_state = WAIT_LOCK;
          w_loss_evt   = 1'b1;
        end else if (r_cnt == HOLD_LAST) begin
          w_next_state = RUN;
        end else begin
          w_cnt_next = r_cnt + CNT_WIDTH'(1);
        end
      end
      RUN: begin
        if (!w_locked_s) begin
          w_next_state = WAIT_LOCK;
          w_loss_evt   = 1'b1;
        end else if (bus.sw_rst_req) begin
          w_next_state = HOLD;
          w_cnt_next   = '0;
        end
      end
      default: begin
        w_next_state = WAIT_LOCK;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Output logic: reset_out_ is registered from the next state so it tracks RUN exactly.
  always_comb begin
    w_reset_out_next  = (w_next_state == RUN);
    bus.reset_out_    = r_reset_out;
    bus.lock_loss_cnt = r_loss_cnt;
    bus.seq_state     = r_state;
  end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq with SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, HOLD_CYCLES=4.
module tb_pll_reset_seq;
  localparam int SYNC = 2;
  localparam int LSC  = 8;
  localparam int HC   = 4;
  localparam int CW   = 4;
  localparam int REL  = SYNC + 1 + LSC + HC;   // 15 edges from lock rise to release

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic reset_ = 1'b1;
  always #5 clk = ~clk;

  pll_reset_seq_if bus ();

  pll_reset_seq #(
    .SYNC_STAGES       (SYNC),
    .LOCK_STABLE_CYCLES(LSC),
    .HOLD_CYCLES       (HC),
    .CNT_WIDTH         (CW)
  ) dut (
    .clk   (clk),
    .reset_(reset_),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Lock as seen by the sequencer is pll_locked delayed by SYNC edges.
  // Progress is tracked as elapsed edges since the stable window opened:
  // [0,LSC) stable, [LSC,LSC+HC) hold, beyond that run.
  bit m_hist[SYNC];
  bit m_wait = 1'b1;
  int m_n    = 0;
  int m_e    = 0;
  int m_loss = 0;

  function automatic int m_state();
    int d;
    if (m_wait) return 0;
    d = m_n - m_e;
    if (d < LSC) return 1;
    if (d < LSC + HC) return 2;
    return 3;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < SYNC; i++) m_hist[i] = 1'b0;
    m_wait = 1'b1;
    m_loss = 0;
  endtask

  task automatic m_step();
    int prior;
    bit seen;
    if (!reset_) begin
      m_clear();
      return;
    end
    prior = m_state();
    seen  = m_hist[SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = bus.pll_locked;
    m_n++;
    if (prior != 0 && !seen) begin
      if (m_loss < 255) m_loss++;
      m_wait = 1'b1;
    end else if (prior == 0 && seen) begin
      m_wait = 1'b0;
      m_e    = m_n;
    end else if (prior == 3 && bus.sw_rst_req) begin
      m_e = m_n - LSC;
    end
  endtask

  initial forever begin
    @(posedge clk);
    m_step();
  end

  initial forever begin
    @(negedge reset_);
    m_clear();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    check("cyc_reset_out", int'(bus.reset_out_), (m_state() == 3) ? 1 : 0);
    check("cyc_state", int'(bus.seq_state), m_state());
    check("cyc_loss", int'(bus.lock_loss_cnt), m_loss);
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int cycles, input logic lock);
    @(negedge clk);
    reset_         = 1'b0;
    bus.pll_locked = lock;
    bus.sw_rst_req = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      check("in_reset_out", int'(bus.reset_out_), 0);
    end
    reset_ = 1'b1;
  endtask

  // Called just before edge 1 of a lock rise (state WAIT_LOCK, lock now high).
  // Optionally pulses sw_rst_req so it is sampled at edge pulse_at+1.
  task automatic expect_release(input string name, input int pulse_at);
    for (int k = 1; k <= REL; k++) begin
      @(negedge clk);
      bus.sw_rst_req = (k == pulse_at);
      check({name, "_rst"}, int'(bus.reset_out_), (k >= REL) ? 1 : 0);
      if (k == 3)   check({name, "_st3"}, int'(bus.seq_state), 1);
      if (k == 11)  check({name, "_st11"}, int'(bus.seq_state), 2);
      if (k == REL) check({name, "_st15"}, int'(bus.seq_state), 3);
    end
    bus.sw_rst_req = 1'b0;
  endtask

  task automatic drop_lock(input int cycles);
    bus.pll_locked = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    bus.pll_locked = 1'b0;
    bus.sw_rst_req = 1'b0;
    #1 reset_ = 1'b0;

    // Power-up with lock already high.
    do_reset(3, 1'b1);
    expect_release("pwrup", 0);
    check("pwrup_loss", int'(bus.lock_loss_cnt), 0);

    // Unstable lock after a fresh reset: 5 high, 3 low, then high.
    do_reset(3, 1'b0);
    repeat (3) @(negedge clk);
    bus.pll_locked = 1'b1;
    repeat (5) @(negedge clk);
    drop_lock(3);
    check("unstable_state", int'(bus.seq_state), 0);
    check("unstable_loss", int'(bus.lock_loss_cnt), 1);
    bus.pll_locked = 1'b1;
    expect_release("unstable", 0);

    // Soft reset in RUN: low 4 cycles, then released.
    repeat (2) @(negedge clk);
    bus.sw_rst_req = 1'b1;
    @(negedge clk);
    bus.sw_rst_req = 1'b0;
    check("soft_edge1", int'(bus.reset_out_), 0);
    check("soft_state", int'(bus.seq_state), 2);
    repeat (3) begin
      @(negedge clk);
      check("soft_low", int'(bus.reset_out_), 0);
    end
    @(negedge clk);
    check("soft_high", int'(bus.reset_out_), 1);

    // Soft reset pulse while STABLE is ignored.
    drop_lock(4);
    check("stable_loss", int'(bus.lock_loss_cnt), 2);
    bus.pll_locked = 1'b1;
    expect_release("stpulse", 5);

    // Lock loss in RUN.
    repeat (2) @(negedge clk);
    drop_lock(3);
    check("loss_rst", int'(bus.reset_out_), 0);
    check("loss_state", int'(bus.seq_state), 0);
    check("loss_cnt", int'(bus.lock_loss_cnt), 3);
    @(negedge clk);
    bus.pll_locked = 1'b1;
    expect_release("relock", 0);

    // Lock loss and soft reset in the same cycle: lock loss wins.
    repeat (2) @(negedge clk);
    bus.pll_locked = 1'b0;
    repeat (2) @(negedge clk);
    bus.sw_rst_req = 1'b1;
    @(negedge clk);
    bus.sw_rst_req = 1'b0;
    check("prio_state", int'(bus.seq_state), 0);
    check("prio_loss", int'(bus.lock_loss_cnt), 4);
    repeat (2) @(negedge clk);

    // 300 short lock events saturate the counter.
    for (int i = 0; i < 300; i++) begin
      bus.pll_locked = 1'b1;
      @(negedge clk);
      bus.pll_locked = 1'b0;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("sat_loss", int'(bus.lock_loss_cnt), 255);

    // Async reset pulse shorter than a cycle while in HOLD.
    bus.pll_locked = 1'b1;
    repeat (12) @(negedge clk);
    check("midhold_state", int'(bus.seq_state), 2);
    #2 reset_ = 1'b0;
    #1;
    check("midhold_rst", int'(bus.reset_out_), 0);
    check("midhold_loss", int'(bus.lock_loss_cnt), 0);
    check("midhold_st0", int'(bus.seq_state), 0);
    #1 reset_ = 1'b1;
    expect_release("midhold", 0);
    check("midhold_loss_end", int'(bus.lock_loss_cnt), 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
